// File: rtl/segment_mem_wb.sv
// MEM/WB pipeline register.
// Captures the MEM-stage data and control on every rising clock edge and
// drives the register-file write-back data from the captured values.
// There is no stall or flush: every edge outside reset advances the stage.
// No valid/ready handshake exists here; RegWrite_out is the only qualifier
// the register file sees, and it is not used to gate the data mux.
module segment_mem_wb #(
  parameter int DATA_W = 22
) (
  input  logic              clk,
  input  logic              reset,          // active-low, asynchronous
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic              MemToReg_in,
  input  logic              RegWrite_in,
  output logic [DATA_W-1:0] write_data_out,
  output logic              MemToReg_out,
  output logic              RegWrite_out
);

  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] alu_q;
  logic              memtoreg_q;
  logic              regwrite_q;

  // Stage register: cleared at once by reset, otherwise loads every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q      <= '0;
      alu_q      <= '0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
    end else begin
      mem_q      <= mem_data_in;
      alu_q      <= alu_result_in;
      memtoreg_q <= MemToReg_in;
      regwrite_q <= RegWrite_in;
    end
  end

  // Write-back source select from registered values only; the unselected
  // register never reaches the output, so its contents cannot leak through.
  always_comb begin
    write_data_out = alu_q;
    if (memtoreg_q) begin
      write_data_out = mem_q;
    end
  end

  assign MemToReg_out = memtoreg_q;
  assign RegWrite_out = regwrite_q;

endmodule

// File: tb/tb_segment_mem_wb.sv
// Bench for the MEM/WB pipeline register: reset behaviour, directed
// write-back cases, between-edge glitches, asynchronous reset pulses,
// unselected-input isolation and randomized traffic against a reference.
module tb_segment_mem_wb;

  localparam int W = 22;
  localparam logic [W-1:0] MASK = {W{1'b1}};

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         reset;
  logic [W-1:0] mem_data_in;
  logic [W-1:0] alu_result_in;
  logic         MemToReg_in;
  logic         RegWrite_in;
  logic [W-1:0] write_data_out;
  logic         MemToReg_out;
  logic         RegWrite_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  segment_mem_wb #(.DATA_W(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_data_in    (mem_data_in),
    .alu_result_in  (alu_result_in),
    .MemToReg_in    (MemToReg_in),
    .RegWrite_in    (RegWrite_in),
    .write_data_out (write_data_out),
    .MemToReg_out   (MemToReg_out),
    .RegWrite_out   (RegWrite_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {write_data, MemToReg, RegWrite} for transactions in flight.
  logic [W+1:0] exp_q[$];

  // Reference: the register file receives memory data when MemToReg is set,
  // otherwise the ALU result; the control bits pass straight through.
  function automatic logic [W+1:0] model_wb(input logic [W-1:0] mem,
                                            input logic [W-1:0] alu,
                                            input logic mtr,
                                            input logic rw);
    logic [W-1:0] d;
    d = mtr ? mem : alu;
    return {d, mtr, rw};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] mem, input logic [W-1:0] alu,
                       input logic mtr, input logic rw);
    mem_data_in   = mem;
    alu_result_in = alu;
    MemToReg_in   = mtr;
    RegWrite_in   = rw;
  endtask

  task automatic drive_random();
    drive(W'($urandom()) & MASK, W'($urandom()) & MASK,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W+1:0] obs;
    reset = 1'b0;
    drive_random();
    #1;
    obs = {write_data_out, MemToReg_out, RegWrite_out};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_before_edge: got %h expected 0", obs);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_random();
      @(posedge clk); #1;
      obs = {write_data_out, MemToReg_out, RegWrite_out};
      n_tests++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_held_edge%0d: got %h expected 0", i, obs);
      end
    end
    // Release away from an edge; the next edge must capture normally.
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    logic [W+1:0] obs;
    logic [W+1:0] exp;
    logic [W+1:0] prev;
    // ALU result selected, write enabled.
    @(negedge clk);
    drive(22'h123456, 22'h3FFFFF, 1'b0, 1'b1);
    // note: args are (mem, alu) order
    drive(22'h3FFFFF, 22'h123456, 1'b0, 1'b1);
    @(posedge clk); #1;
    obs = {write_data_out, MemToReg_out, RegWrite_out};
    exp = {22'h123456, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL directed_alu_sel: got %h expected %h", obs, exp);
    end
    prev = exp;
    // Memory data selected; before the edge the old values must hold.
    @(negedge clk);
    drive(22'h254321, 22'h2BCDEF, 1'b1, 1'b1);
    #1;
    obs = {write_data_out, MemToReg_out, RegWrite_out};
    n_tests++;
    if (obs !== prev) begin
      n_fail++;
      $display("FAIL directed_hold_before_edge: got %h expected %h", obs, prev);
    end
    @(posedge clk); #1;
    obs = {write_data_out, MemToReg_out, RegWrite_out};
    exp = {22'h254321, 1'b1, 1'b1};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL directed_mem_sel: got %h expected %h", obs, exp);
    end
    // Mux still acts with RegWrite low.
    @(negedge clk);
    drive(22'h222222, 22'h111111, 1'b0, 1'b0);
    @(posedge clk); #1;
    obs = {write_data_out, MemToReg_out, RegWrite_out};
    exp = {22'h111111, 1'b0, 1'b0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL directed_regwrite_low: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_glitch();
    logic [W+1:0] obs;
    logic [W+1:0] held;
    @(negedge clk);
    drive(22'h0ABCDE, 22'h155555, 1'b1, 1'b1);
    @(posedge clk); #1;
    held = model_wb(22'h0ABCDE, 22'h155555, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_random();
      #1;
      obs = {write_data_out, MemToReg_out, RegWrite_out};
      n_tests++;
      if (obs !== held) begin
        n_fail++;
        $display("FAIL glitch_no_edge%0d: got %h expected %h", i, obs, held);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W+1:0] obs;
    logic [W+1:0] exp;
    @(negedge clk);
    drive(22'h3A5A5A, 22'h05A5A5, 1'b0, 1'b1);
    @(posedge clk); #1;
    obs = {write_data_out, MemToReg_out, RegWrite_out};
    exp = {22'h05A5A5, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL async_pre_reset: got %h expected %h", obs, exp);
    end
    // Pulse reset between edges.
    #1;
    reset = 1'b0;
    #1;
    obs = {write_data_out, MemToReg_out, RegWrite_out};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h expected 0", obs);
    end
    #1;
    reset = 1'b1;
    #1;
    obs = {write_data_out, MemToReg_out, RegWrite_out};
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL async_reset_released_no_edge: got %h expected 0", obs);
    end
    @(negedge clk);
    drive(22'h1F0F0F, 22'h20F0F0, 1'b1, 1'b1);
    @(posedge clk); #1;
    obs = {write_data_out, MemToReg_out, RegWrite_out};
    exp = model_wb(22'h1F0F0F, 22'h20F0F0, 1'b1, 1'b1);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL async_after_release: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_unselected_x();
    logic [W+1:0] obs;
    logic [W+1:0] exp;
    @(negedge clk);
    drive('x, 22'h2468AC, 1'b0, 1'b1);
    @(posedge clk); #1;
    obs = {write_data_out, MemToReg_out, RegWrite_out};
    exp = {22'h2468AC, 1'b0, 1'b1};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL unselected_mem_x: got %h expected %h", obs, exp);
    end
    @(negedge clk);
    drive(22'h13579B, 'x, 1'b1, 1'b0);
    @(posedge clk); #1;
    obs = {write_data_out, MemToReg_out, RegWrite_out};
    exp = {22'h13579B, 1'b1, 1'b0};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL unselected_alu_x: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] obs;
    logic [W+1:0] exp;
    exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      drive_random();
      exp_q.push_back(model_wb(mem_data_in, alu_result_in,
                               MemToReg_in, RegWrite_in));
      @(posedge clk); #1;
      obs = {write_data_out, MemToReg_out, RegWrite_out};
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL random_queue_empty: cycle %0d", i);
      end else begin
        exp = exp_q.pop_front();
        n_tests++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL random_cycle%0d: got %h expected %h", i, obs, exp);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_glitch();
    test_async_reset();
    test_unselected_x();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/segment_mem_wb.md
SEGMENT_MEM_WB -- requirements
Module: segment_mem_wb

Interface
REQ-001 Parameter: DATA_W, default 22, width of the data paths (mem_data_in, alu_result_in, write_data_out).
REQ-002 The block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: mem_data_in  input  DATA_W  data read from data memory in the MEM stage.
REQ-006 Port: alu_result_in  input  DATA_W  ALU result forwarded from the MEM stage.
REQ-007 Port: MemToReg_in  input  1  write-back source select (1 = memory data, 0 = ALU result).
REQ-008 Port: RegWrite_in  input  1  register-file write enable from the MEM stage.
REQ-009 Port: write_data_out  output  DATA_W  selected write-back data for the register file.
REQ-010 Port: MemToReg_out  output  1  registered MemToReg.
REQ-011 Port: RegWrite_out  output  1  registered RegWrite.

Function
REQ-012 The block SHALL be the MEM/WB pipeline register, with internal registers mem_q, alu_q, memtoreg_q and regwrite_q.
REQ-013 While reset is deasserted, each rising clk edge SHALL capture mem_data_in, alu_result_in, MemToReg_in and RegWrite_in into those registers unconditionally (no stall or flush port).
REQ-014 write_data_out SHALL be combinational from the registers: mem_q when memtoreg_q=1, else alu_q.
REQ-015 MemToReg_out SHALL equal memtoreg_q, and RegWrite_out SHALL equal regwrite_q.
REQ-016 Latency from input change to output SHALL be exactly one clk rising edge, with no combinational path from inputs to outputs.
REQ-017 Data SHALL pass through without modification: no sign extension, truncation beyond DATA_W or arithmetic.
REQ-018 The write-back mux SHALL act when RegWrite=0: write_data_out still reflects the selected source, and only RegWrite_out gates the write.
REQ-019 X/Z on an unselected data input SHALL NOT propagate to write_data_out.

Reset
REQ-020 Asserting reset (low) SHALL clear all four registers immediately, independent of clk.
REQ-021 During reset, write_data_out, MemToReg_out and RegWrite_out SHALL all be 0.
REQ-022 Reset asserted in the middle of operation SHALL discard the in-flight stage contents; no write-back SHALL occur (RegWrite_out=0).
REQ-023 On reset release, the first rising edge SHALL capture the inputs normally.
REQ-024 If reset is released in the same timestep as a clk edge, that edge's capture is not required; capture SHALL occur by the next edge.

Verification
REQ-025 Reset low with arbitrary inputs -> all outputs 0 before any clk edge, and they stay 0 across edges while reset is held.
REQ-026 Reset high, alu=0x123456, mem=0x3FFFFF, MemToReg=0, RegWrite=1, one edge -> write_data_out=0x123456, MemToReg_out=0, RegWrite_out=1.
REQ-027 Next cycle alu=0x2BCDEF, mem=0x254321, MemToReg=1, RegWrite=1 -> after the edge write_data_out=0x254321, MemToReg_out=1; before the edge the outputs still hold the prior values.
REQ-028 Next cycle alu=0x111111, mem=0x222222, MemToReg=0, RegWrite=0 -> write_data_out=0x111111, RegWrite_out=0.
REQ-029 Inputs changed between edges (no edge) -> outputs unchanged; an input glitch SHALL NOT reach the outputs.
REQ-030 Reset pulsed low asynchronously while RegWrite_out=1 -> all outputs 0 immediately; after release and one edge, outputs reflect the current inputs.
